multi_sel_rx: RTL

- Receive-side companion to the multiply-select transmitter.
- Consumes the transmitter's 4-word frame, one 11-bit word per cycle: d×1, d×3, d×7, d×8, with frame_start marking the ×1 word.
- Recovers the 8-bit operand, checks every word against the expected multiple, and reports result, error and abort status.
- Sits directly on the transmitter's out/input_grant wires in loopback and self-check paths.

---
 rtl/multi_sel_rx.sv | 97 +++++++++
 1 files changed

// File: rtl/multi_sel_rx.sv
// Receiver for the multiply-select frame (d x1, x3, x7, x8): recovers the operand,
// checks every word against its expected multiple, and reports frame/abort status.
// state | meaning
// IDLE  | waiting for frame_start with the x1 word
// W3    | expecting d x3
// W7    | expecting d x7
// W8    | expecting d x8; result registered on exit
module multi_sel_rx #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [10:0]      word,
  output logic [7:0]       d_out,
  output logic             d_valid,
  output logic             d_err,
  output logic             abort,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, W3, W7, W8} state_t;

  state_t      state;
  logic [7:0]  d_cap;
  logic        err_acc;
  logic [10:0] dx;
  logic [10:0] mul3;
  logic [10:0] mul7;
  logic [10:0] mul8;
  logic        err_fin;

  // 11 bits holds 8 x 255 exactly, so none of these can wrap
  always_comb begin
    dx      = {3'b000, d_cap};
    mul3    = dx + (dx << 1);
    mul7    = (dx << 3) - dx;
    mul8    = dx << 3;
    err_fin = err_acc | (word != mul8);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      d_cap     <= 8'h00;
      err_acc   <= 1'b0;
      d_out     <= 8'h00;
      d_valid   <= 1'b0;
      d_err     <= 1'b0;
      abort     <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      d_valid <= 1'b0;
      abort   <= 1'b0;
      if (frame_start) begin
        // a new frame always wins; anything in flight is dropped
        d_cap   <= word[7:0];
        err_acc <= |word[10:8];
        state   <= W3;
        busy    <= 1'b1;
        if (state != IDLE) abort <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          W3: begin
            err_acc <= err_acc | (word != mul3);
            state   <= W7;
          end
          W7: begin
            err_acc <= err_acc | (word != mul7);
            state   <= W8;
          end
          W8: begin
            d_valid <= 1'b1;
            d_out   <= d_cap;
            d_err   <= err_fin;
            state   <= IDLE;
            busy    <= 1'b0;
            if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
            if (err_fin && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
